// File: rtl/mem_bist_pkg.sv
// Shared constants, state/phase types and the test-pattern generator for the
// 32 x 8 memory BIST sequencer and its bench.
package mem_bist_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned ERR_W  = 8;
    localparam int unsigned NUM_PH = 3;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        WAIT,
        NEXT_PH,
        DONE
    } bist_state_t;

    typedef enum logic [1:0] {
        PH_CLEAR,
        PH_ADDR,
        PH_CHKR
    } bist_phase_t;

    function automatic logic [DATA_W-1:0] bist_pattern(input bist_phase_t phase,
                                                       input logic [ADDR_W-1:0] addr);
        case (phase)
            PH_CLEAR: return '0;
            PH_ADDR:  return DATA_W'(addr);
            PH_CHKR:  return addr[0] ? DATA_W'(8'hAA) : DATA_W'(8'h55);
            default:  return '0;
        endcase
    endfunction

    // Lowest enabled phase in the mask; caller guarantees mask != 0.
    function automatic bist_phase_t lowest_phase(input logic [NUM_PH-1:0] mask);
        if (mask[0]) return PH_CLEAR;
        if (mask[1]) return PH_ADDR;
        return PH_CHKR;
    endfunction

    function automatic logic [NUM_PH-1:0] phase_bit(input bist_phase_t phase);
        case (phase)
            PH_CLEAR: return NUM_PH'(3'b001);
            PH_ADDR:  return NUM_PH'(3'b010);
            default:  return NUM_PH'(3'b100);
        endcase
    endfunction

endpackage

// File: rtl/mem_bist_ctrl.sv
// Memory BIST sequencer: write-then-read-back passes over the whole memory for
// each enabled phase, counting mismatches and latching the first failing address.
module mem_bist_ctrl
    import mem_bist_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        phase_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              mem_write,
    output logic              mem_read,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic              first_err_valid,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam int unsigned LAT_W = 3;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RD_LATENCY - 1);

    bist_state_t       state, state_nxt;
    bist_phase_t       phase, phase_nxt;
    logic [NUM_PH-1:0] pending, pending_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [LAT_W-1:0]  lat_cnt, lat_nxt;
    logic              mismatch;

    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_data_in_nxt;
    logic              mem_write_nxt, mem_read_nxt, busy_nxt, done_nxt, pass_nxt;
    logic [ERR_W-1:0]  err_nxt;
    logic              fev_nxt;
    logic [ADDR_W-1:0] fea_nxt;

    // State, counters and all outputs are registered from their next values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            phase           <= PH_CLEAR;
            pending         <= '0;
            addr            <= '0;
            lat_cnt         <= '0;
            mem_addr        <= '0;
            mem_data_in     <= '0;
            mem_write       <= 1'b0;
            mem_read        <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
        end else begin
            state           <= state_nxt;
            phase           <= phase_nxt;
            pending         <= pending_nxt;
            addr            <= addr_nxt;
            lat_cnt         <= lat_nxt;
            mem_addr        <= mem_addr_nxt;
            mem_data_in     <= mem_data_in_nxt;
            mem_write       <= mem_write_nxt;
            mem_read        <= mem_read_nxt;
            busy            <= busy_nxt;
            done            <= done_nxt;
            pass            <= pass_nxt;
            err_count       <= err_nxt;
            first_err_valid <= fev_nxt;
            first_err_addr  <= fea_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        phase_nxt   = phase;
        pending_nxt = pending;
        addr_nxt    = addr;
        lat_nxt     = lat_cnt;
        err_nxt     = err_count;
        fev_nxt     = first_err_valid;
        fea_nxt     = first_err_addr;
        done_nxt    = done;
        pass_nxt    = pass;
        mismatch    = (mem_data_out != bist_pattern(phase, addr));

        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (start) begin
                    addr_nxt = '0;
                    lat_nxt  = '0;
                    err_nxt  = '0;
                    fev_nxt  = 1'b0;
                    fea_nxt  = '0;
                    done_nxt = 1'b0;
                    pass_nxt = 1'b0;
                    if (phase_en != '0) begin
                        phase_nxt   = lowest_phase(phase_en);
                        pending_nxt = phase_en & ~phase_bit(phase_nxt);
                        state_nxt   = WR;
                    end else begin
                        pending_nxt = '0;
                        state_nxt   = DONE;
                    end
                end
            end
            WR: begin
                addr_nxt = addr + ADDR_W'(1);
                if (addr == LAST_ADDR) state_nxt = RD;
            end
            RD: begin
                lat_nxt   = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                // Read data is only valid in the last latency cycle.
                if (lat_cnt == LAT_LAST) begin
                    if (mismatch) begin
                        if (err_count != '1) err_nxt = err_count + ERR_W'(1);
                        if (!first_err_valid) begin
                            fev_nxt = 1'b1;
                            fea_nxt = addr;
                        end
                    end
                    addr_nxt  = addr + ADDR_W'(1);
                    state_nxt = (addr == LAST_ADDR) ? NEXT_PH : RD;
                end else begin
                    lat_nxt = lat_cnt + LAT_W'(1);
                end
            end
            NEXT_PH: begin
                if (pending != '0) begin
                    phase_nxt   = lowest_phase(pending);
                    pending_nxt = pending & ~phase_bit(phase_nxt);
                    state_nxt   = WR;
                end else begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (state_nxt == DONE) begin
            done_nxt = 1'b1;
            pass_nxt = (err_nxt == '0);
        end

        busy_nxt        = (state_nxt != IDLE) && (state_nxt != DONE);
        mem_write_nxt   = (state_nxt == WR);
        mem_read_nxt    = (state_nxt == RD);
        mem_addr_nxt    = (mem_write_nxt || mem_read_nxt) ? addr_nxt : '0;
        mem_data_in_nxt = mem_write_nxt ? bist_pattern(phase_nxt, addr_nxt) : '0;
    end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: behavioural memories with injectable faults, a bus
// scoreboard of expected transactions and a queue of expected run results.
module tb_mem_bist_ctrl;
    import mem_bist_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              start, start3;
    logic [2:0]        phase_en, phase_en3;
    logic [ADDR_W-1:0] mem_addr, mem_addr3, first_err_addr, first_err_addr3;
    logic [DATA_W-1:0] mem_data_in, mem_data_in3, mem_data_out, mem_data_out3;
    logic              mem_write, mem_write3, mem_read, mem_read3;
    logic              busy, busy3, done, done3, pass, pass3;
    logic [ERR_W-1:0]  err_count, err_count3;
    logic              first_err_valid, first_err_valid3;

    mem_bist_ctrl #(.RD_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .start(start), .phase_en(phase_en),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .mem_write(mem_write), .mem_read(mem_read), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .first_err_valid(first_err_valid),
        .first_err_addr(first_err_addr)
    );

    mem_bist_ctrl #(.RD_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .phase_en(phase_en3),
        .mem_addr(mem_addr3), .mem_data_in(mem_data_in3), .mem_data_out(mem_data_out3),
        .mem_write(mem_write3), .mem_read(mem_read3), .busy(busy3), .done(done3),
        .pass(pass3), .err_count(err_count3), .first_err_valid(first_err_valid3),
        .first_err_addr(first_err_addr3)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // fault: 0 clean, 1 bit0 of addr 7 stuck-at-1, 2 addr bit4 tied to 0
    int fault = 0;
    logic [DATA_W-1:0] mem0 [0:DEPTH-1];
    logic [DATA_W-1:0] mem1 [0:DEPTH-1];
    logic [DATA_W-1:0] rd0, p0, p1, p2;
    logic [ADDR_W-1:0] eff_addr;

    assign eff_addr = (fault == 2) ? {1'b0, mem_addr[ADDR_W-2:0]} : mem_addr;

    always @(posedge clk) begin
        if (mem_write) mem0[eff_addr] <= mem_data_in;
        if (mem_read)  rd0 <= mem0[eff_addr] |
                              ((fault == 1 && mem_addr == 5'd7) ? 8'h01 : 8'h00);
    end
    assign mem_data_out = rd0;

    always @(posedge clk) begin
        if (mem_write3) mem1[mem_addr3] <= mem_data_in3;
        p0 <= mem_read3 ? mem1[mem_addr3] : 8'h00;
        p1 <= p0;
        p2 <= p1;
    end
    assign mem_data_out3 = p2;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } bus_t;

    typedef struct {
        int                lat;
        logic              pass;
        int                err;
        logic              fev;
        logic [ADDR_W-1:0] fea;
    } res_t;

    bus_t bq0[$], bq1[$];
    res_t rq0[$], rq1[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   last_rd3 = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_bus(input int which, input logic [2:0] mask);
        bus_t e;
        for (int p = 0; p < 3; p++) begin
            if (mask[p]) begin
                for (int a = 0; a < 32; a++) begin
                    e.wr   = 1'b1;
                    e.addr = ADDR_W'(a);
                    e.data = bist_pattern(bist_phase_t'(2'(p)), e.addr);
                    if (which == 0) bq0.push_back(e); else bq1.push_back(e);
                end
                for (int a = 0; a < 32; a++) begin
                    e.wr   = 1'b0;
                    e.addr = ADDR_W'(a);
                    e.data = '0;
                    if (which == 0) bq0.push_back(e); else bq1.push_back(e);
                end
            end
        end
    endtask

    task automatic mon(input int which);
        logic              wr, rd;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        bus_t              e;
        int                qs;
        if (which == 0) begin
            wr = mem_write;  rd = mem_read;  a = mem_addr;  d = mem_data_in;  qs = bq0.size();
        end else begin
            wr = mem_write3; rd = mem_read3; a = mem_addr3; d = mem_data_in3; qs = bq1.size();
        end
        if (wr || rd) begin
            chk("bus_excl", 32'(wr & rd), 32'd0);
            if (qs == 0) begin
                chk("bus_unexpected", 32'({wr, rd}), 32'd0);
            end else begin
                if (which == 0) e = bq0.pop_front(); else e = bq1.pop_front();
                chk("bus_kind", 32'(wr), 32'(e.wr));
                chk("bus_addr", 32'(a), 32'(e.addr));
                chk(e.wr ? "bus_wdata" : "bus_rd_din0", 32'(d), 32'(e.data));
                if (which == 1 && rd) begin
                    if (last_rd3 >= 0) chk("rd_spacing", 32'(cyc - last_rd3), 32'd4);
                    last_rd3 = cyc;
                end
            end
        end
    endtask

    task automatic run(input int which, input logic [2:0] mask, input int exp_err,
                       input logic exp_fev, input logic [ADDR_W-1:0] exp_fea);
        res_t r;
        int   lat_rd, t0, n;
        logic d_o, b_o, p_o, v_o;
        logic [ERR_W-1:0]  e_o;
        logic [ADDR_W-1:0] f_o;
        lat_rd = (which == 0) ? 1 : 3;
        r.lat  = $countones(mask) * (32 + 32 * (1 + lat_rd) + 1) + 1;
        r.err  = exp_err;
        r.pass = (exp_err == 0);
        r.fev  = exp_fev;
        r.fea  = exp_fea;
        push_bus(which, mask);
        if (which == 0) rq0.push_back(r); else rq1.push_back(r);

        @(negedge clk);
        t0 = cyc;
        if (which == 0) begin start = 1'b1; phase_en = mask; end
        else begin start3 = 1'b1; phase_en3 = mask; end
        @(negedge clk);
        start = 1'b0; start3 = 1'b0;
        b_o = (which == 0) ? busy : busy3;
        chk("busy_after_start", 32'(b_o), 32'(mask != 3'b000));
        n = 0;
        d_o = (which == 0) ? done : done3;
        while (!d_o && n < 2000) begin
            @(negedge clk);
            n++;
            d_o = (which == 0) ? done : done3;
        end
        chk("done_seen", 32'(d_o), 32'd1);
        if (which == 0) begin
            r = rq0.pop_front();
            p_o = pass;  e_o = err_count;  v_o = first_err_valid;  f_o = first_err_addr;
            b_o = busy;
        end else begin
            r = rq1.pop_front();
            p_o = pass3; e_o = err_count3; v_o = first_err_valid3; f_o = first_err_addr3;
            b_o = busy3;
        end
        chk("done_latency", 32'(cyc - t0), 32'(r.lat));
        chk("busy_at_done", 32'(b_o), 32'd0);
        chk("pass", 32'(p_o), 32'(r.pass));
        chk("err_count", 32'(e_o), 32'(r.err));
        chk("first_err_valid", 32'(v_o), 32'(r.fev));
        chk("first_err_addr", 32'(f_o), 32'(r.fea));
        chk("bus_all_seen", 32'((which == 0) ? bq0.size() : bq1.size()), 32'd0);
    endtask

    task automatic chk_outputs_zero(input string ctx);
        chk({ctx, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({ctx, "_mem_data_in"}, 32'(mem_data_in), 32'd0);
        chk({ctx, "_mem_write"}, 32'(mem_write), 32'd0);
        chk({ctx, "_mem_read"}, 32'(mem_read), 32'd0);
        chk({ctx, "_busy"}, 32'(busy), 32'd0);
        chk({ctx, "_done"}, 32'(done), 32'd0);
        chk({ctx, "_pass"}, 32'(pass), 32'd0);
        chk({ctx, "_err_count"}, 32'(err_count), 32'd0);
        chk({ctx, "_first_err_valid"}, 32'(first_err_valid), 32'd0);
        chk({ctx, "_first_err_addr"}, 32'(first_err_addr), 32'd0);
    endtask

    initial begin
        int t0;
        rst = 1'b1; start = 1'b0; start3 = 1'b0; phase_en = '0; phase_en3 = '0;
        fork
            forever begin @(negedge clk); mon(0); end
            forever begin @(negedge clk); mon(1); end
        join_none

        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        chk("reset_busy3", 32'(busy3), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // clean memory, all phases
        fault = 0;
        run(0, 3'b111, 0, 1'b0, 5'd0);
        // bit0 stuck-at-1 at addr 7: clear and checkerboard fail, data=address passes
        fault = 1;
        run(0, 3'b111, 2, 1'b1, 5'd7);
        // addr bit4 tied low: lower half reads back upper-half data
        fault = 2;
        run(0, 3'b010, 16, 1'b1, 5'd0);
        // empty mask finishes immediately with no bus traffic
        fault = 0;
        run(0, 3'b000, 0, 1'b0, 5'd0);

        // second start while busy is ignored; reset mid-run aborts cleanly
        push_bus(0, 3'b111);
        @(negedge clk);
        t0 = cyc;
        start = 1'b1; phase_en = 3'b111;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + 20) @(negedge clk);
        start = 1'b1; phase_en = 3'b001;
        @(negedge clk);
        start = 1'b0;
        chk("busy_ignored_start", 32'(busy), 32'd1);
        while (cyc < t0 + 50) @(negedge clk);
        chk("busy_before_rst", 32'(busy), 32'd1);
        chk("done_before_rst", 32'(done), 32'd0);
        #1;
        rst = 1'b1;
        bq0.delete();
        @(negedge clk);
        chk_outputs_zero("midrun_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("idle_after_rst", 32'({mem_write, mem_read, busy}), 32'd0);
        end
        run(0, 3'b111, 0, 1'b0, 5'd0);

        // longer read latency, checkerboard only
        run(1, 3'b100, 0, 1'b0, 5'd0);

        repeat (3) @(negedge clk);
        chk("bus_q0_empty", 32'(bq0.size()), 32'd0);
        chk("bus_q1_empty", 32'(bq1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bist_ctrl.md
Name: mem_bist_ctrl

Overview:
- Hardware built-in self-test sequencer for the 32 x 8 synchronous memory. It drives the memory bus in place of a software test.
- Runs up to three write-then-read-back phases: clear, data=address, and checkerboard.
- Counts mismatches, latches the first failing address, and reports pass/fail.
- Sits beside the memory as the master on its bus; start comes from the top-level test controller.

Parameters:
- ADDR_W, 5, memory address width (DEPTH = 2**ADDR_W = 32)
- DATA_W, 8, memory data width
- RD_LATENCY, 1, cycles from the read-asserted cycle to the cycle in which mem_data_out is valid (legal range 1..4)

Ports:
- clk  in  1  single clock, all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to run the test; honoured only when busy=0
- phase_en  in  3  phase mask, sampled with start: bit0 clear, bit1 data=address, bit2 checkerboard
- mem_addr  out  ADDR_W  memory address
- mem_data_in  out  DATA_W  write data to memory
- mem_data_out  in  DATA_W  read data from memory
- mem_write  out  1  memory write strobe
- mem_read  out  1  memory read strobe
- busy  out  1  test in progress
- done  out  1  level; set when a run completes, cleared by the next accepted start or by rst
- pass  out  1  valid while done=1; 1 iff err_count==0
- err_count  out  8  mismatch count, saturates at 255
- first_err_valid  out  1  at least one mismatch seen in this run
- first_err_addr  out  ADDR_W  address of the first mismatch

Behaviour:
- Reset values:
  - all outputs 0: mem_addr, mem_data_in, mem_write, mem_read, busy, done, pass, err_count, first_err_valid, first_err_addr
  - FSM in IDLE
- Reset mid-run: the run aborts at that edge and the bus is idle the next cycle. No partial results are retained.
- States: IDLE, WR, RD, WAIT, NEXT_PH, DONE.
- IDLE:
  - start=1 and phase_en!=0: latch the mask, clear counters and first_err_*, clear done, go to WR of the lowest enabled phase, addr=0.
  - start=1 and phase_en==0: go to DONE directly (pass=1, err_count=0).
- WR:
  - One write per cycle: mem_write=1, mem_addr=addr, mem_data_in=pattern(phase, addr).
  - After addr 31: addr wraps to 0 and the FSM goes to RD.
- RD: mem_read=1 and mem_addr=addr for one cycle, then WAIT.
- WAIT:
  - Lasts RD_LATENCY cycles; strobes are low.
  - In the final WAIT cycle, compare mem_data_out with pattern(phase, addr).
  - On mismatch: err_count+1 (saturating). If first_err_valid=0, set it and latch first_err_addr.
  - Then go to RD for addr+1, or to NEXT_PH after addr 31.
- NEXT_PH: one idle cycle, then WR of the next enabled phase in bit order, or DONE if none remain.
- DONE: done=1, pass=(err_count==0), busy=0, then return to IDLE. Results hold until the next accepted start.
- busy=1 in every state except IDLE and DONE.
- Bus rules:
  - mem_write and mem_read are never asserted together.
  - mem_data_in = 0 when mem_write=0.
- Patterns:
  - clear = 8'h00
  - data=address = zero-extended addr
  - checkerboard = 8'h55 for even addr, 8'hAA for odd addr
- Cycle count per phase: 32 + 32*(1+RD_LATENCY) + 1. With the default latency this is 97 cycles.
- Timing (RD_LATENCY=1, all phases enabled, start accepted at edge E0):
  - busy=1 from E0+1.
  - done=1 at E0+292.
- start while busy=1 is ignored. It has no effect on the current run or its results.

Decomposition:
- Shared package mem_bist_pkg holds:
  - ADDR_W, DATA_W, DEPTH constants
  - bist_state_t enum and bist_phase_t enum (PH_CLEAR, PH_ADDR, PH_CHKR)
  - pure function bist_pattern(phase, addr)
- The test bench reuses bist_pattern for its expected values.
- No sub-module. The latency counter and comparator stay inline.

Test Plan:
- Clean memory, phase_en=3'b111, start pulse -> exactly 32 writes and 32 reads per phase; done=1 at E0+292; pass=1; err_count=0; first_err_valid=0.
- Memory model with bit0 of addr 7 stuck-at-1, phase_en=3'b111 ->
  - clear phase fails at addr 7 (expect 00, read 01)
  - data=address phase passes at addr 7
  - checkerboard fails at addr 7 (expect AA, read AB)
  - result: err_count=2, first_err_addr=7, pass=0
- Memory model with addr bit4 tied to 0 (aliasing), phase_en=3'b010 -> addrs 0..15 read 16..31; err_count=16; first_err_addr=0.
- phase_en=3'b000 with start -> done=1 one cycle after start; pass=1; no mem_write or mem_read ever asserted.
- Second start pulse while busy, then rst asserted at cycle 50 of a run ->
  - the second start has no effect
  - after rst, all outputs are 0 the next cycle and the bus stays idle
  - a fresh start then completes with pass=1
- RD_LATENCY=3, memory model with 3-cycle read latency, phase_en=3'b100 -> 161 cycles of the phase; pass=1; mem_read asserted every 4th cycle during the read pass.
